fx2_fifo_ctrl: RTL

FX2_FIFO_CTRL -- requirements
Module: fx2_fifo_ctrl

---
 rtl/fx2_fifo_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/fx2_fifo_ctrl.sv
// fx2_fifo_ctrl: slave-FIFO controller for a Cypress FX2 in synchronous mode.
// EP2 (host->device) is drained into a 2-entry buffer feeding the out_* stream;
// the in_* stream is written into EP6. Bursts are capped at BURST_MAX words
// while the opposite direction waits, and every endpoint switch goes through
// a one-cycle TURN with the bus released.
// Optional feature: define FX2_PKTEND_EN to commit short IN packets with
// fx2_pktend after PKTEND_TIMEOUT idle cycles.
module fx2_fifo_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int BURST_MAX      = 16,
  parameter int PKTEND_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fx2_fd_i,
  output logic [DATA_WIDTH-1:0] fx2_fd_o,
  output logic                  fx2_fd_oe,
  output logic                  fx2_sloe,
  output logic                  fx2_slrd,
  output logic                  fx2_slwr,
  output logic                  fx2_pktend,
  output logic [1:0]            fx2_fifoadr,
  input  logic                  fx2_ep2_empty_n,
  input  logic                  fx2_ep6_full_n,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready
);

  typedef enum logic [2:0] {IDLE, RD, WR, TURN, PEND} state_t;

  localparam logic [1:0] ADR_EP2 = 2'b00;
  localparam logic [1:0] ADR_EP6 = 2'b10;
  localparam int BW = $clog2(BURST_MAX + 1);

  state_t          state_reg, state_next;
  state_t          turn_target_reg, turn_target_next;
  state_t          target;
  logic            go;
  logic [1:0]      fifoadr_reg, fifoadr_next;
  logic            last_wr_reg;          // 1 = write side was served last
  logic [BW-1:0]   burst_cnt_reg;
  logic            burst_last;

  logic [DATA_WIDTH-1:0] buf_mem [0:1];
  logic            wr_ptr_reg, rd_ptr_reg;
  logic [1:0]      buf_cnt_reg;

  logic            read_pending, write_pending;
  logic            rd_xfer, wr_xfer, pop;
  logic            timeout_hit;

  function automatic logic [1:0] addr_of(input state_t s);
    return (s == RD) ? ADR_EP2 : ADR_EP6;
  endfunction

  assign read_pending  = fx2_ep2_empty_n && (buf_cnt_reg != 2'd2);
  assign write_pending = in_valid && fx2_ep6_full_n;
  assign rd_xfer       = (state_reg == RD) && read_pending;
  assign wr_xfer       = (state_reg == WR) && write_pending;
  assign pop           = (buf_cnt_reg != 2'd0) && out_ready;
  assign burst_last    = (burst_cnt_reg == BW'(BURST_MAX - 1));

`ifdef FX2_PKTEND_EN
  localparam int CW = $clog2(PKTEND_TIMEOUT + 1);
  // The PEND decision is taken while the counter is two short so that the
  // strobe lands exactly PKTEND_TIMEOUT cycles after the last write strobe.
  localparam logic [CW-1:0] PEND_AT = CW'(PKTEND_TIMEOUT - 2);

  logic            pkt_flag_reg;
  logic [CW-1:0]   idle_cnt_reg;

  // Track uncommitted IN words and count idle cycles since the last write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_flag_reg <= 1'b0;
      idle_cnt_reg <= '0;
    end else if (state_reg == PEND) begin
      pkt_flag_reg <= 1'b0;
      idle_cnt_reg <= '0;
    end else if (wr_xfer) begin
      pkt_flag_reg <= 1'b1;
      idle_cnt_reg <= '0;
    end else if (pkt_flag_reg && idle_cnt_reg != PEND_AT) begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = pkt_flag_reg && (idle_cnt_reg == PEND_AT);
  assign fx2_pktend  = (state_reg != PEND);
`else
  assign timeout_hit = 1'b0;
  assign fx2_pktend  = 1'b1;
`endif

  // Arbitration and transitions; any endpoint change is routed through TURN
  always_comb begin
    state_next       = state_reg;
    turn_target_next = turn_target_reg;
    fifoadr_next     = fifoadr_reg;
    target           = IDLE;
    go               = 1'b0;
    case (state_reg)
      IDLE: begin
        if (timeout_hit) begin
          target = PEND;
          go     = 1'b1;
        end else if (read_pending && (!write_pending || last_wr_reg)) begin
          target = RD;
          go     = 1'b1;
        end else if (write_pending) begin
          target = WR;
          go     = 1'b1;
        end
      end
      RD: begin
        if (!read_pending || burst_last) begin
          if (write_pending) begin
            target = WR;
            go     = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      WR: begin
        if (!write_pending || burst_last) begin
          if (read_pending) begin
            target = RD;
            go     = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      TURN:    state_next = turn_target_reg;
      PEND:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (go) begin
      fifoadr_next = addr_of(target);
      if (addr_of(target) != fifoadr_reg) begin
        state_next       = TURN;
        turn_target_next = target;
      end else begin
        state_next = target;
      end
    end
  end

  // State, endpoint address, fairness bit and per-visit burst counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      turn_target_reg <= IDLE;
      fifoadr_reg     <= ADR_EP2;
      last_wr_reg     <= 1'b1;
      burst_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      turn_target_reg <= turn_target_next;
      fifoadr_reg     <= fifoadr_next;
      if (state_reg == RD)      last_wr_reg <= 1'b0;
      else if (state_reg == WR) last_wr_reg <= 1'b1;
      if (state_next != state_reg)  burst_cnt_reg <= '0;
      else if (rd_xfer || wr_xfer)  burst_cnt_reg <= burst_cnt_reg + 1'b1;
    end
  end

  // OUT buffer occupancy and pointers; capture and pop may share a cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      buf_cnt_reg <= 2'd0;
    end else begin
      if (rd_xfer) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)     rd_ptr_reg <= ~rd_ptr_reg;
      case ({rd_xfer, pop})
        2'b10:   buf_cnt_reg <= buf_cnt_reg + 2'd1;
        2'b01:   buf_cnt_reg <= buf_cnt_reg - 2'd1;
        default: buf_cnt_reg <= buf_cnt_reg;
      endcase
    end
  end

  // OUT buffer storage: FX2 data is captured on the edge that ends an slrd cycle
  always_ff @(posedge clk) begin
    if (rd_xfer) buf_mem[wr_ptr_reg] <= fx2_fd_i;
  end

  assign out_valid   = (buf_cnt_reg != 2'd0);
  assign out_data    = buf_mem[rd_ptr_reg];
  assign fx2_fifoadr = fifoadr_reg;
  assign fx2_sloe    = (state_reg != RD);
  assign fx2_slrd    = ~rd_xfer;
  assign fx2_fd_oe   = (state_reg == WR);
  assign fx2_fd_o    = (state_reg == WR) ? in_data : '0;
  assign fx2_slwr    = ~wr_xfer;
  assign in_ready    = wr_xfer;

endmodule
